// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT input deserializer.
package fft_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PARL_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/deser_bank.sv
// One ping-pong frame store: sample slots plus the EMPTY/FILLING/FULL tracker.
module deser_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PARL_WIDTH = PARL_WIDTH_DEF,
    localparam int IDX_W     = $clog2(PARL_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  last_i,
    input  logic                  rd_ack_i,
    output bank_state_t           state_o,
    output logic [DATA_WIDTH-1:0] data_o [PARL_WIDTH]
);

    bank_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q [PARL_WIDTH];

    // Bank state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BANK_EMPTY;
        else        state_q <= state_d;
    end

    // Next bank state: clear wins, then a write, then consumption of a full frame.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = BANK_EMPTY;
        end else if (wr_en_i) begin
            state_d = last_i ? BANK_FULL : BANK_FILLING;
        end else if (rd_ack_i && (state_q == BANK_FULL)) begin
            state_d = BANK_EMPTY;
        end
    end

    // Sample slots; contents survive a clear, only reset zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PARL_WIDTH; k++) data_q[k] <= '0;
        end else if (wr_en_i) begin
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign state_o = state_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fft_deserializer.sv
// Serial-to-parallel front end of the FFT: gap-free ping-pong frame assembly.
module fft_deserializer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PARL_WIDTH = PARL_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  dir,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] par [PARL_WIDTH],
    output logic                  ovf
);

    localparam int             CNT_W    = $clog2(PARL_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PARL_WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             ovf_q, ovf_d;

    bank_state_t           st0, st1;
    logic [DATA_WIDTH-1:0] data0 [PARL_WIDTH];
    logic [DATA_WIDTH-1:0] data1 [PARL_WIDTH];

    logic             accept, take, frame_dir, last;
    logic [CNT_W-1:0] wr_idx;

    // Handshake status comes purely from registered bank state.
    assign in_ready  = (wr_bank_q ? st1 : st0) != BANK_FULL;
    assign out_valid = (rd_bank_q ? st1 : st0) == BANK_FULL;
    assign accept    = in_valid && in_ready && !clr;
    assign take      = out_valid && out_ready && !clr;

    // The first sample of a frame uses the live dir; the rest use the latched copy.
    assign frame_dir = (cnt_q == '0) ? dir : dir_q;
    assign wr_idx    = frame_dir ? (LAST_CNT - cnt_q) : cnt_q;
    assign last      = (cnt_q == LAST_CNT);
    assign ovf       = ovf_q;

    deser_bank #(.DATA_WIDTH(DATA_WIDTH), .PARL_WIDTH(PARL_WIDTH)) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .wr_en_i  (accept && !wr_bank_q),
        .wr_idx_i (wr_idx),
        .wr_data_i(in_data),
        .last_i   (last),
        .rd_ack_i (take && !rd_bank_q),
        .state_o  (st0),
        .data_o   (data0)
    );

    deser_bank #(.DATA_WIDTH(DATA_WIDTH), .PARL_WIDTH(PARL_WIDTH)) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .wr_en_i  (accept && wr_bank_q),
        .wr_idx_i (wr_idx),
        .wr_data_i(in_data),
        .last_i   (last),
        .rd_ack_i (take && rd_bank_q),
        .state_o  (st1),
        .data_o   (data1)
    );

    // Output frame always reflects the read-side bank.
    always_comb begin
        for (int k = 0; k < PARL_WIDTH; k++) par[k] = rd_bank_q ? data1[k] : data0[k];
    end

    // Sample counter, direction latch, bank pointers and sticky overflow.
    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        ovf_d     = ovf_q;
        if (clr) begin
            cnt_d     = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            ovf_d     = 1'b0;
        end else begin
            if (accept) begin
                if (cnt_q == '0) dir_d = dir;
                if (last) begin
                    cnt_d     = '0;
                    wr_bank_d = !wr_bank_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (take) rd_bank_d = !rd_bank_q;
            if (in_valid && !in_ready) ovf_d = 1'b1;
        end
    end

    // Control register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fft_deserializer.sv
// Bench for fft_deserializer (DATA_WIDTH=8, PARL_WIDTH=4) against a frame-queue model.
module tb_fft_deserializer;

    logic       clk, rst_n, clr, dir, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [7:0] in_data;
    logic [7:0] par [4];

    int errors = 0;
    int checks = 0;

    // Reference model: completed frames waiting for the core, plus one partial frame.
    logic [31:0] fq [$];
    logic [7:0]  pf [4];
    int          pcnt;
    bit          pdir;
    bit          movf;

    fft_deserializer #(.DATA_WIDTH(8), .PARL_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .dir      (dir),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .par      (par),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] par_word();
        return {par[3], par[2], par[1], par[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        pcnt = 0;
        movf = 1'b0;
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(fq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(fq.size() > 0));
        chk("ovf", 32'(ovf), 32'(movf));
        if (fq.size() > 0) chk("par", par_word(), fq[0]);
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        bit rdy, ack;
        if (clr) begin
            model_clear();
        end else begin
            rdy = (fq.size() < 2);
            ack = out_ready && (fq.size() > 0);
            if (in_valid && !rdy) movf = 1'b1;
            if (ack) void'(fq.pop_front());
            if (in_valid && rdy) begin
                if (pcnt == 0) pdir = dir;
                pf[pdir ? 3 - pcnt : pcnt] = in_data;
                pcnt++;
                if (pcnt == 4) begin
                    fq.push_back({pf[3], pf[2], pf[1], pf[0]});
                    pcnt = 0;
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit dr, input bit ordy, input bit c);
        in_valid  = v;
        in_data   = d;
        dir       = dr;
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        dir       = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        rst_n     = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Reset / idle state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_par", par_word(), 32'd0);

        // dir=0 streaming, second frame follows with no stall
        step(1, 8'h11, 0, 1, 0);
        step(1, 8'h22, 0, 1, 0);
        step(1, 8'h33, 0, 1, 0);
        step(1, 8'h44, 0, 1, 0);
        chk("fwd_valid", 32'(out_valid), 32'd1);
        chk("fwd_par", par_word(), 32'h44332211);
        step(1, 8'h55, 0, 1, 0);
        step(1, 8'h66, 0, 1, 0);
        step(1, 8'h77, 0, 1, 0);
        step(1, 8'h88, 0, 1, 0);
        chk("fwd2_par", par_word(), 32'h88776655);
        step(0, 8'h00, 0, 1, 0);

        // dir=1 reversal, toggling dir mid-frame has no effect
        step(1, 8'hA1, 1, 1, 0);
        step(1, 8'hA2, 1, 1, 0);
        step(1, 8'hA3, 0, 1, 0);
        step(1, 8'hA4, 0, 1, 0);
        chk("rev_par", par_word(), 32'hA1A2A3A4);
        step(0, 8'h00, 0, 1, 0);

        // Backpressure: both banks fill, then overflow is flagged
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        step(1, 8'h09, 0, 0, 0);
        chk("bp_ovf", 32'(ovf), 32'd1);
        chk("bp_frame1", par_word(), 32'h04030201);
        step(0, 8'h00, 0, 1, 0);
        chk("bp_valid2", 32'(out_valid), 32'd1);
        chk("bp_frame2", par_word(), 32'h08070605);
        step(0, 8'h00, 0, 1, 0);
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(ovf), 32'd1);

        // clr drops ovf; then complete bank 1 while bank 0 is consumed
        step(0, 8'h00, 0, 0, 1);
        chk("clr_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(1, 8'h23, 0, 1, 0);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_par", par_word(), 32'h23222120);
        chk("sim_in_ready", 32'(in_ready), 32'd1);
        step(0, 8'h00, 0, 1, 0);

        // clr mid-frame discards the partial frame
        step(1, 8'h30, 0, 1, 0);
        step(1, 8'h31, 0, 1, 0);
        step(0, 8'h00, 0, 1, 1);
        chk("clr_no_frame", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        chk("clr_fresh", par_word(), 32'h43424140);
        step(0, 8'h00, 0, 1, 0);

        // Reset mid-frame discards the partial frame
        step(1, 8'h50, 0, 0, 0);
        step(1, 8'h51, 0, 0, 0);
        do_reset();
        chk("rstmid_no_frame", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 1, 0, 0);
        chk("rstmid_fresh", par_word(), 32'h60616263);
        step(0, 8'h00, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
